bitonic_sort_sequencer: RTL

- Sorts a block of N words by time-multiplexing one compare-exchange unit over an internal N-entry register buffer.
- Sequence per block:
  - LOAD: accepts N words over a valid/ready input stream.
  - SORT: walks the full bitonic network, one compare-exchange pair per cycle.
  - OUT: streams the sorted block out over a valid/ready output stream.
- Sits between a word producer and a consumer; replaces an N·log²N parallel network where area matters more than throughput.

---
 rtl/bitonic_sort_sequencer_pkg.sv | 22 ++
 rtl/bitonic_sort_sequencer_if.sv | 23 ++
 rtl/bitonic_sort_sequencer_cae.sv | 19 +
 rtl/bitonic_sort_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/bitonic_sort_sequencer_pkg.sv
// Shared types and index helpers for the bitonic sort sequencer.
package bitonic_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    OUT
  } state_t;

  // Number of compare-exchange cycles for a full bitonic network over 2**log_n words.
  function automatic int unsigned sort_cycles(input int unsigned log_n);
    return (32'd1 << (log_n - 1)) * log_n * (log_n + 1) / 2;
  endfunction

  // Lower index of pair p in a pass of span j (j one-hot): p with a 0 inserted at bit log2(j).
  function automatic int unsigned pair_index(input int unsigned p, input int unsigned j);
    int unsigned low_mask;
    low_mask = j - 1;
    return ((p & ~low_mask) << 1) | (p & low_mask);
  endfunction

endpackage

// File: rtl/bitonic_sort_sequencer_if.sv
// Input and output word streams of the bitonic sort sequencer.
interface bitonic_sort_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             dir;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output dir, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  dir, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bitonic_sort_sequencer_cae.sv
// Combinational compare-exchange: orders two words ascending or descending.
module bitonic_cae #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             asc,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  logic swap;

  // Swap only on strict disorder so equal words stay in place.
  always_comb begin
    swap = asc ? (a > b) : (a < b);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end
endmodule

// File: rtl/bitonic_sort_sequencer.sv
// Sorts a block of 2**LOG_N words with a single time-shared compare-exchange unit.
module bitonic_sort_sequencer
  import bitonic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LOG_N = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     busy,
  bitonic_sort_sequencer_if.slave  bus
);
  localparam int N    = 1 << LOG_N;
  localparam int HALF = N / 2;
  localparam int SW   = $clog2(LOG_N + 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] mem [N];
  logic [LOG_N-1:0] load_cnt, out_cnt, p_cnt;
  logic [SW-1:0]    st_cnt, j_sh;
  logic             dir_q;

  logic             in_fire, out_fire;
  logic             p_last, j_last, st_last, sort_last;
  logic [LOG_N-1:0] j_oh, idx_i, idx_l;
  logic [LOG_N:0]   k_oh;
  logic             asc;
  logic [WIDTH-1:0] lo, hi;

  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign p_last    = (p_cnt == LOG_N'(HALF - 1));
  assign j_last    = (j_sh == '0);
  assign st_last   = (st_cnt == SW'(LOG_N - 1));
  assign sort_last = p_last && j_last && st_last;

  // Current pair indices and direction from the stage (k), span (j) and pair (p) counters.
  always_comb begin
    j_oh  = LOG_N'(1) << j_sh;
    k_oh  = (LOG_N + 1)'(2) << st_cnt;
    idx_i = LOG_N'(pair_index(32'(p_cnt), 32'(j_oh)));
    idx_l = idx_i | j_oh;
    asc   = ((({1'b0, idx_i}) & k_oh) == '0) ^ dir_q;
  end

  bitonic_cae #(.WIDTH(WIDTH)) u_cae (
    .a   (mem[idx_i]),
    .b   (mem[idx_l]),
    .asc (asc),
    .lo  (lo),
    .hi  (hi)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  // Phase sequencing; an abort wins over any handshake in the same cycle.
  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = LOAD;
    end else begin
      case (state)
        LOAD:    if (in_fire && load_cnt == LOG_N'(N - 1)) state_nx = SORT;
        SORT:    if (sort_last) state_nx = OUT;
        OUT:     if (out_fire && out_cnt == LOG_N'(N - 1)) state_nx = LOAD;
        default: state_nx = LOAD;
      endcase
    end
  end

  // Stream handshakes and status decoded from the phase.
  always_comb begin
    bus.in_ready  = (state == LOAD);
    bus.out_valid = (state == OUT);
    bus.out_data  = (state == OUT) ? mem[out_cnt] : '0;
    bus.out_last  = (state == OUT) && (out_cnt == LOG_N'(N - 1));
    busy          = (state != LOAD);
  end

  // Buffer, direction latch and the load/sort/output counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < N; n++) mem[n] <= '0;
      load_cnt <= '0;
      out_cnt  <= '0;
      p_cnt    <= '0;
      st_cnt   <= '0;
      j_sh     <= '0;
      dir_q    <= 1'b0;
    end else if (clr) begin
      load_cnt <= '0;
      out_cnt  <= '0;
      p_cnt    <= '0;
      st_cnt   <= '0;
      j_sh     <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            mem[load_cnt] <= bus.in_data;
            if (load_cnt == '0) dir_q <= bus.dir;
            load_cnt <= load_cnt + LOG_N'(1);
          end
        end
        SORT: begin
          mem[idx_i] <= lo;
          mem[idx_l] <= hi;
          if (p_last) begin
            p_cnt <= '0;
            if (j_last) begin
              if (st_last) begin
                st_cnt <= '0;
                j_sh   <= '0;
              end else begin
                st_cnt <= st_cnt + SW'(1);
                j_sh   <= st_cnt + SW'(1);
              end
            end else begin
              j_sh <= j_sh - SW'(1);
            end
          end else begin
            p_cnt <= p_cnt + LOG_N'(1);
          end
        end
        OUT: begin
          if (out_fire) out_cnt <= out_cnt + LOG_N'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
